// File: rtl/bus_master_arb_mux.sv
// Shared-bus arbiter and master multiplexer: registers one bus owner out of
// NUM_MASTERS requesters (fixed priority or round-robin), optionally forces a
// handover after a bounded hold time, and steers the owner's address/strobe/
// read-write/write-data onto the slave side.
module bus_master_arb_mux #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_W      = 30,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ARB_MODE    = 1,
  parameter int unsigned MAX_HOLD    = 0,
  parameter int unsigned OWN_W       = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req_,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_as_,
  input  logic [NUM_MASTERS-1:0]        m_rw,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
  output logic [NUM_MASTERS-1:0]        m_grnt_,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_as_,
  output logic                          s_rw,
  output logic [DATA_W-1:0]             s_wr_data,
  output logic [OWN_W-1:0]              owner,
  output logic                          owner_vld
);

  // Hold counter saturates at MAX_HOLD-1; keep at least one bit when unused.
  localparam int unsigned HOLD_LIM = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam int unsigned HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [OWN_W-1:0]       r_owner;
  logic [OWN_W-1:0]       w_owner_nxt;
  logic [OWN_W-1:0]       r_last;
  logic [OWN_W-1:0]       w_last_nxt;
  logic [HOLD_W-1:0]      r_hold;
  logic [HOLD_W-1:0]      w_hold_nxt;
  logic [NUM_MASTERS-1:0] r_grnt_;
  logic [NUM_MASTERS-1:0] w_grnt_nxt_;

  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_req_oth;
  logic                   w_own_req;
  logic                   w_own_as_;
  logic                   w_preempt;
  logic [OWN_W:0]         w_pick_all;
  logic [OWN_W:0]         w_pick_oth;

  // Returns {found, index}: lowest index in fixed mode, otherwise the first
  // requester at or after last+1 with wrap-around.
  function automatic logic [OWN_W:0] f_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [OWN_W-1:0]       last);
    logic             found;
    logic [OWN_W-1:0] win;
    int unsigned      idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (ARB_MODE == 0) idx = k;
      else               idx = (32'(last) + 32'd1 + k) % NUM_MASTERS;
      if (!found && req[OWN_W'(idx)]) begin
        found = 1'b1;
        win   = OWN_W'(idx);
      end
    end
    return {found, win};
  endfunction

  assign w_req      = ~m_req_;
  assign w_pick_all = f_pick(w_req, r_last);
  assign w_pick_oth = f_pick(w_req_oth, r_last);

  // Owner-selected request/strobe and the slave-side mux (idle values when unowned).
  always_comb begin
    w_own_req = 1'b0;
    w_own_as_ = 1'b1;
    w_req_oth = '0;
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      w_req_oth[i] = w_req[i] && (r_owner != OWN_W'(i));
      if ((r_state == OWNED) && (r_owner == OWN_W'(i))) begin
        w_own_req = w_req[i];
        w_own_as_ = m_as_[i];
        s_addr    = m_addr[i*ADDR_W +: ADDR_W];
        s_as_     = m_as_[i];
        s_rw      = m_rw[i];
        s_wr_data = m_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Forced handover: hold time used up, someone else waiting, owner between accesses.
  assign w_preempt = (MAX_HOLD > 0) && (r_hold == HOLD_W'(HOLD_LIM)) &&
                     (|w_req_oth) && w_own_as_;

  // Next owner, round-robin pointer, hold counter and grant vector.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    w_grnt_nxt_ = '1;
    case (r_state)
      IDLE: begin
        if (w_pick_all[OWN_W]) begin
          w_state_nxt = OWNED;
          w_owner_nxt = w_pick_all[OWN_W-1:0];
          w_last_nxt  = w_pick_all[OWN_W-1:0];
          w_hold_nxt  = '0;
        end
      end
      OWNED: begin
        if (!w_own_req || w_preempt) begin
          w_hold_nxt = '0;
          if (w_pick_oth[OWN_W]) begin
            w_owner_nxt = w_pick_oth[OWN_W-1:0];
            w_last_nxt  = w_pick_oth[OWN_W-1:0];
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (r_hold != HOLD_W'(HOLD_LIM)) begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if ((w_state_nxt == OWNED) && (w_owner_nxt == OWN_W'(i))) w_grnt_nxt_[i] = 1'b0;
    end
  end

  // State and grant registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= OWN_W'(NUM_MASTERS - 1);
      r_hold  <= '0;
      r_grnt_ <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
      r_grnt_ <= w_grnt_nxt_;
    end
  end

  assign m_grnt_   = r_grnt_;
  assign owner     = r_owner;
  assign owner_vld = (r_state == OWNED);

endmodule

// File: tb/tb_bus_master_arb_mux.sv
// Bench for bus_master_arb_mux: a round-robin instance with bounded hold, a
// fixed-priority instance sharing its inputs, and a two-master instance.
module tb_bus_master_arb_mux;

  logic         clk;
  logic         reset;
  logic [3:0]   m_req_;
  logic [3:0]   m_as_;
  logic [3:0]   m_rw;
  logic [119:0] m_addr;
  logic [127:0] m_wr_data;

  logic [3:0]  rr_grnt_, fp_grnt_;
  logic [29:0] rr_s_addr, fp_s_addr;
  logic        rr_s_as_, fp_s_as_, rr_s_rw, fp_s_rw;
  logic [31:0] rr_s_wr_data, fp_s_wr_data;
  logic [1:0]  rr_owner, fp_owner;
  logic        rr_owner_vld, fp_owner_vld;

  logic [1:0]  n2_req_, n2_as_, n2_rw, n2_grnt_;
  logic [59:0] n2_addr;
  logic [63:0] n2_wr_data;
  logic [29:0] n2_s_addr;
  logic        n2_s_as_, n2_s_rw, n2_owner, n2_owner_vld;
  logic [31:0] n2_s_wr_data;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req_;
    logic [3:0] as_;
    logic [3:0] exp_;
    logic       sel;   // 0: round-robin instance, 1: fixed-priority instance
  } vec_t;

  typedef struct {
    logic [3:0] exp_;
    logic       sel;
    int         idx;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  bus_master_arb_mux #(.NUM_MASTERS(4), .ADDR_W(30), .DATA_W(32), .ARB_MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .reset(reset), .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw),
    .m_wr_data(m_wr_data), .m_grnt_(rr_grnt_), .s_addr(rr_s_addr), .s_as_(rr_s_as_),
    .s_rw(rr_s_rw), .s_wr_data(rr_s_wr_data), .owner(rr_owner), .owner_vld(rr_owner_vld));

  bus_master_arb_mux #(.NUM_MASTERS(4), .ADDR_W(30), .DATA_W(32), .ARB_MODE(0), .MAX_HOLD(0)) u_fp (
    .clk(clk), .reset(reset), .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw),
    .m_wr_data(m_wr_data), .m_grnt_(fp_grnt_), .s_addr(fp_s_addr), .s_as_(fp_s_as_),
    .s_rw(fp_s_rw), .s_wr_data(fp_s_wr_data), .owner(fp_owner), .owner_vld(fp_owner_vld));

  bus_master_arb_mux #(.NUM_MASTERS(2), .ADDR_W(30), .DATA_W(32), .ARB_MODE(1), .MAX_HOLD(4)) u_n2 (
    .clk(clk), .reset(reset), .m_req_(n2_req_), .m_addr(n2_addr), .m_as_(n2_as_), .m_rw(n2_rw),
    .m_wr_data(n2_wr_data), .m_grnt_(n2_grnt_), .s_addr(n2_s_addr), .s_as_(n2_s_as_),
    .s_rw(n2_s_rw), .s_wr_data(n2_s_wr_data), .owner(n2_owner), .owner_vld(n2_owner_vld));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h (t=%0t)", name, idx, got, exp, $time);
    end
  endtask

  function automatic void add(input logic rst, input logic [3:0] req_, input logic [3:0] as_,
                              input logic [3:0] exp_, input logic sel);
    vecs.push_back('{rst: rst, req_: req_, as_: as_, exp_: exp_, sel: sel});
  endfunction

  // Apply each vector for one edge; the expected grant is queued at drive time.
  task automatic run_vecs(input string name);
    sb_t        e;
    logic [3:0] got;
    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst;
      m_req_ = vecs[i].req_;
      m_as_  = vecs[i].as_;
      sb.push_back('{exp_: vecs[i].exp_, sel: vecs[i].sel, idx: i});
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      got = e.sel ? fp_grnt_ : rr_grnt_;
      chk(name, e.idx, 32'(got), 32'(e.exp_));
    end
    vecs.delete();
  endtask

  // Never two grants low on any instance.
  always @(negedge clk) begin
    n_chk++;
    if ($countones(~rr_grnt_) > 1 || $countones(~fp_grnt_) > 1 || $countones(~n2_grnt_) > 1) begin
      n_fail++;
      $display("FAIL one_grant: rr=%b fp=%b n2=%b (t=%0t)", rr_grnt_, fp_grnt_, n2_grnt_, $time);
    end
  end

  initial begin
    reset  = 1'b1;
    m_req_ = 4'b0000;
    m_as_  = 4'b0000;
    m_rw   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_addr[i*30 +: 30]    = 30'($urandom) | 30'h1;
      m_wr_data[i*32 +: 32] = $urandom | 32'h1;
    end
    n2_req_    = 2'b11;
    n2_as_     = 2'b11;
    n2_rw      = 2'b00;
    n2_addr    = {30'h155, 30'h2AA};
    n2_wr_data = {32'h1111_2222, 32'h3333_4444};
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state, with every master requesting.
    chk("rst_rr_grnt", 0, 32'(rr_grnt_), 32'hF);
    chk("rst_fp_grnt", 0, 32'(fp_grnt_), 32'hF);
    chk("rst_n2_grnt", 0, 32'(n2_grnt_), 32'h3);
    chk("rst_owner_vld", 0, 32'(rr_owner_vld), 32'h0);
    chk("rst_owner", 0, 32'(rr_owner), 32'h0);
    chk("rst_s_as", 0, 32'(rr_s_as_), 32'h1);
    chk("rst_s_addr", 0, 32'(rr_s_addr), 32'h0);
    chk("rst_s_rw", 0, 32'(rr_s_rw), 32'h1);
    chk("rst_s_wr_data", 0, rr_s_wr_data, 32'h0);

    // Fixed priority: 1 beats 3, no preemption of 3 by 0, lowest index on release.
    add(0, 4'b0101, 4'b1111, 4'b1101, 1);
    add(0, 4'b0101, 4'b1111, 4'b1101, 1);
    add(0, 4'b0111, 4'b1111, 4'b0111, 1);
    add(0, 4'b0110, 4'b1111, 4'b0111, 1);
    add(0, 4'b0110, 4'b1111, 4'b0111, 1);
    add(0, 4'b1110, 4'b1111, 4'b1110, 1);
    add(0, 4'b1101, 4'b1111, 4'b1101, 1);
    add(0, 4'b0100, 4'b1111, 4'b1101, 1);
    add(0, 4'b0110, 4'b1111, 4'b1110, 1);
    add(0, 4'b1111, 4'b1111, 4'b1111, 1);
    run_vecs("fixed_prio");

    // Round-robin rotation: every master owns 3 cycles, no idle gap.
    add(1, 4'b1111, 4'b1111, 4'b1111, 0);
    add(0, 4'b0000, 4'b1111, 4'b1110, 0);
    add(0, 4'b0000, 4'b1111, 4'b1110, 0);
    add(0, 4'b0000, 4'b1111, 4'b1110, 0);
    add(0, 4'b0001, 4'b1111, 4'b1101, 0);
    add(0, 4'b0000, 4'b1111, 4'b1101, 0);
    add(0, 4'b0000, 4'b1111, 4'b1101, 0);
    add(0, 4'b0010, 4'b1111, 4'b1011, 0);
    add(0, 4'b0000, 4'b1111, 4'b1011, 0);
    add(0, 4'b0000, 4'b1111, 4'b1011, 0);
    add(0, 4'b0100, 4'b1111, 4'b0111, 0);
    add(0, 4'b0000, 4'b1111, 4'b0111, 0);
    add(0, 4'b0000, 4'b1111, 4'b0111, 0);
    add(0, 4'b1000, 4'b1111, 4'b1110, 0);
    add(0, 4'b0000, 4'b1111, 4'b1110, 0);
    run_vecs("rr_rotate");

    // Preemption after the 4th owned cycle; preempted master re-wins later.
    add(1, 4'b1111, 4'b1111, 4'b1111, 0);
    add(0, 4'b1110, 4'b1111, 4'b1110, 0);
    add(0, 4'b1100, 4'b1111, 4'b1110, 0);
    add(0, 4'b1100, 4'b1111, 4'b1110, 0);
    add(0, 4'b1100, 4'b1111, 4'b1110, 0);
    add(0, 4'b1100, 4'b1111, 4'b1101, 0);
    add(0, 4'b1100, 4'b1111, 4'b1101, 0);
    add(0, 4'b1110, 4'b1111, 4'b1110, 0);
    add(0, 4'b1111, 4'b1111, 4'b1111, 0);
    run_vecs("preempt");

    // Preemption deferred while the owner's strobe is low; saturated counter fires at once.
    add(1, 4'b1111, 4'b1111, 4'b1111, 0);
    add(0, 4'b1110, 4'b1111, 4'b1110, 0);
    add(0, 4'b1100, 4'b1110, 4'b1110, 0);
    add(0, 4'b1100, 4'b1110, 4'b1110, 0);
    add(0, 4'b1100, 4'b1110, 4'b1110, 0);
    add(0, 4'b1100, 4'b1110, 4'b1110, 0);
    add(0, 4'b1100, 4'b1110, 4'b1110, 0);
    add(0, 4'b1100, 4'b1111, 4'b1101, 0);
    add(0, 4'b1111, 4'b1111, 4'b1111, 0);
    run_vecs("preempt_defer");

    // Reset while master 2 owns mid-access.
    add(1, 4'b1111, 4'b1111, 4'b1111, 0);
    add(0, 4'b1011, 4'b1011, 4'b1011, 0);
    add(0, 4'b1011, 4'b1011, 4'b1011, 0);
    add(1, 4'b1011, 4'b1011, 4'b1111, 0);
    run_vecs("rst_mid");
    chk("rst_mid_s_as", 0, 32'(rr_s_as_), 32'h1);
    chk("rst_mid_s_addr", 0, 32'(rr_s_addr), 32'h0);
    chk("rst_mid_vld", 0, 32'(rr_owner_vld), 32'h0);
    add(0, 4'b1010, 4'b1111, 4'b1110, 0);
    add(0, 4'b1010, 4'b1111, 4'b1110, 0);
    run_vecs("rst_after");

    // Mux data path: master 1 owns; other masters' inputs must not leak through.
    reset  = 1'b1;
    m_req_ = 4'b1111;
    @(posedge clk); #1;
    reset  = 1'b0;
    m_req_ = 4'b1101;
    m_as_  = 4'b1111;
    @(posedge clk); #1;
    chk("mux_grnt", 0, 32'(rr_grnt_), 32'hD);
    chk("mux_owner", 0, 32'(rr_owner), 32'h1);
    chk("mux_vld", 0, 32'(rr_owner_vld), 32'h1);
    m_addr[30 +: 30]    = 30'h0000_1234;
    m_rw[1]             = 1'b0;
    m_wr_data[32 +: 32] = 32'hDEAD_BEEF;
    m_as_[1]            = 1'b0;
    #1;
    chk("mux_addr", 0, 32'(rr_s_addr), 32'h0000_1234);
    chk("mux_rw", 0, 32'(rr_s_rw), 32'h0);
    chk("mux_wdata", 0, rr_s_wr_data, 32'hDEAD_BEEF);
    chk("mux_as", 0, 32'(rr_s_as_), 32'h0);
    chk("mux_fp_addr", 0, 32'(fp_s_addr), 32'h0000_1234);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (i != 1) begin
          m_addr[i*30 +: 30]    = 30'($urandom);
          m_wr_data[i*32 +: 32] = $urandom;
          m_rw[i]               = 1'($urandom);
          m_as_[i]              = 1'($urandom);
        end
      end
      #1;
      chk("mux_iso_addr", k, 32'(rr_s_addr), 32'h0000_1234);
      chk("mux_iso_wdata", k, rr_s_wr_data, 32'hDEAD_BEEF);
      chk("mux_iso_rw_as", k, 32'({rr_s_rw, rr_s_as_}), 32'h0);
    end
    @(posedge clk); #1;
    m_addr[30 +: 30] = 30'h2AAA_5555;
    m_rw[1]          = 1'b1;
    #1;
    chk("mux_follow_addr", 0, 32'(rr_s_addr), 32'h2AAA_5555);
    chk("mux_follow_rw", 0, 32'(rr_s_rw), 32'h1);
    m_req_ = 4'b1111;
    m_as_  = 4'b1111;
    @(posedge clk); #1;
    chk("mux_release_grnt", 0, 32'(rr_grnt_), 32'hF);
    chk("mux_release_addr", 0, 32'(rr_s_addr), 32'h0);

    // Two masters, single long requester: never preempted.
    n2_req_ = 2'b10;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      chk("n2_hold", c, 32'(n2_grnt_), 32'h2);
    end
    chk("n2_owner", 0, 32'({n2_owner_vld, n2_owner}), 32'h2);
    n2_req_ = 2'b11;
    @(posedge clk); #1;
    chk("n2_release", 0, 32'(n2_grnt_), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
